lcd_byte_scheduler: RTL and testbench
=====================================

// Module: lcd_byte_scheduler
// PURPOSE
//  Sequences HD44780 bytes onto the PCF8574 I2C backpack through i2c_master.
//  Takes (rs, byte) commands on a valid/ready port and splits each into four
//  single-byte I2C writes: hi-nibble EN=1, hi EN=0, lo EN=1, lo EN=0.
//  After each byte it holds off for the controller execution delay.
//  Sits between the LCD init/message sequencers and i2c_master.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  CMD_DELAY_US  50           post-byte hold-off, normal commands and data
//  CLR_DELAY_US  2000         post-byte hold-off for rs=0 bytes 0x01/0x02/0x03
//  BACKLIGHT     1            value driven on expander bit 3
//  BUSY_TO_CYC   1_000_000    cycles allowed for i2c_busy to rise after ena
// PORTS
//  clk            in   1  system clock
//  reset_n        in   1  synchronous, active-low reset
//  in_valid       in   1  command byte offered
//  in_ready       out  1  scheduler can accept a byte this cycle
//  in_rs          in   1  0 = instruction, 1 = data
//  in_data        in   8  HD44780 byte
//  i2c_ena        out  1  transaction request to i2c_master
//  i2c_data_wr    out  8  expander byte {nib[3:0], BACKLIGHT, en, 1'b0, rs}
//  i2c_busy       in   1  i2c_master busy
//  i2c_ack_error  in   1  i2c_master ack error (valid while busy)
//  idle           out  1  no byte in flight and no hold-off running
//  err_sticky     out  1  latched ack error or busy timeout
//  err_clr        in   1  clears err_sticky
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, in_ready=1, i2c_ena=0,
//   i2c_data_wr=8'h08 (BACKLIGHT=1, all else 0), idle=1, err_sticky=0,
//   counters=0. Reset mid-byte abandons it; i2c_master is reset by its own
//   reset_n, which is tied to this block's reset_n.
//  Accept: in_valid & in_ready at a posedge latches rs/data. in_ready=1 only
//   in IDLE. The next cycle is ISSUE, nib_idx=0.
//  States:
//   IDLE -> ISSUE on accept.
//   ISSUE: i2c_data_wr=frame(nib_idx), i2c_ena=1 -> WAIT_HI.
//   WAIT_HI: hold ena and data until i2c_busy=1, then ena=0 -> WAIT_LO.
//    If busy_to_cnt reaches BUSY_TO_CYC: ena=0, err_sticky=1, byte dropped
//    -> DELAY.
//   WAIT_LO: while busy, i2c_ack_error=1 sets err_sticky. On busy 1->0:
//    nib_idx<3 -> nib_idx+1, ISSUE; nib_idx==3 -> DELAY.
//   DELAY: count down the hold-off, then IDLE (in_ready=1 next cycle).
//  Frame by nib_idx: 0 = {d[7:4],BL,1,0,rs}; 1 = {d[7:4],BL,0,0,rs};
//   2 = {d[3:0],BL,1,0,rs}; 3 = {d[3:0],BL,0,0,rs}.
//  i2c_data_wr is held stable from ISSUE through the end of WAIT_LO.
//  Delay counts: CLK_HZ/1_000_000*US, computed as localparams. The counter is
//   wide enough for the CLR count (>=18 bits at defaults). The long delay
//   applies only when rs=0 and data is in {8'h01, 8'h02, 8'h03}.
//  Ack errors never abort a byte; all four nibbles are still sent.
//  err_clr in the same cycle as a new error: the error wins (err_sticky=1).
//  i2c_ack_error outside WAIT_LO is ignored.
//  idle = (state==IDLE). Byte-to-byte throughput is 4 I2C transactions plus
//   the hold-off.
// STRUCTURE
//  Shared package lcd_pkg: expander bit positions (RS=0, RW=1, EN=2, BL=3,
//   D4..D7=4..7), state encoding, HD44780 opcodes (CLEAR=8'h01, HOME=8'h02,
//   FUNC_4BIT_2L=8'h28, DISP_ON=8'h0C, ENTRY_INC=8'h06, DDRAM_L2=8'hC0).
//  One sub-module, lcd_delay_timer: load/count/done down-counter used by
//   DELAY. The busy timeout uses an inline counter. Single FSM otherwise.
// TESTING
//  Bench: behavioural i2c_master model, busy rises 3-20 cycles after ena and
//   lasts N cycles; CLK_HZ=1_000_000 to shorten the delays.
//  1 rs=1, data=8'h48 ('H') -> i2c_data_wr seq 8'h4D,8'h49,8'h8D,8'h89;
//    exactly 4 ena pulses; in_ready low until 50 cycles after the 4th busy
//    fall.
//  2 rs=0, data=8'h01 -> frames 8'h0C,8'h08,8'h1C,8'h18; hold-off 2000 cycles;
//    data=8'h28 -> hold-off 50 cycles.
//  3 Model asserts ack_error during the 2nd transaction -> err_sticky=1, all 4
//    frames still sent; err_clr pulse -> err_sticky=0.
//  4 Model never raises busy -> after BUSY_TO_CYC cycles ena=0, err_sticky=1;
//    block returns to IDLE after the hold-off.
//  5 in_valid held high with 3 bytes back-to-back -> each accepted only when
//    in_ready=1; 12 frames in order; no byte lost or duplicated.
//  6 reset_n=0 during WAIT_LO of nibble 2 -> next cycle: ena=0, data=8'h08,
//    idle=1, in_ready=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: PCF8574 expander bit map, scheduler states, HD44780 opcodes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lcd_pkg;

   // PCF8574 backpack wiring: D4..D7 occupy bits 4..7.
   localparam int RS_BIT = 0;
   localparam int RW_BIT = 1;
   localparam int EN_BIT = 2;
   localparam int BL_BIT = 3;
   localparam int D4_BIT = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_DELAY   = 3'd4
   } state_t;

   localparam logic [7:0] OP_CLEAR        = 8'h01;
   localparam logic [7:0] OP_HOME         = 8'h02;
   localparam logic [7:0] OP_FUNC_4BIT_2L = 8'h28;
   localparam logic [7:0] OP_DISP_ON      = 8'h0C;
   localparam logic [7:0] OP_ENTRY_INC    = 8'h06;
   localparam logic [7:0] OP_DDRAM_L2     = 8'hC0;

   // Expander byte for nibble slot idx: idx[1] picks low nibble, idx[0]=0 is the EN=1 phase.
   function automatic logic [7:0] make_frame(input logic rs, input logic [7:0] d,
                                             input logic [1:0] idx, input logic bl);
      logic [7:0] f;
      f                 = '0;
      f[D4_BIT +: 4]    = idx[1] ? d[3:0] : d[7:4];
      f[BL_BIT]         = bl;
      f[EN_BIT]         = ~idx[0];
      f[RW_BIT]         = 1'b0;
      f[RS_BIT]         = rs;
      return f;
   endfunction

   // Clear/home (and 0x03, which the controller also treats as home) need the long hold-off.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d == OP_CLEAR || d == OP_HOME || d == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Load/count-down timer for the post-byte hold-off.
// Latency: done goes high load_val cycles after the load cycle.
// Backpressure: none; load overrides an in-progress count.
// Ports: clk, reset_n (sync, active low), load + load_val start a count, done = count is zero.
module lcd_delay_timer #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_byte_scheduler.sv
// Splits (rs, byte) LCD commands into four PCF8574 writes via i2c_master, then holds off.
// Latency: accept -> first i2c_ena 2 cycles; byte done after 4 I2C transactions + hold-off.
// Backpressure: in_ready high only in IDLE; one byte in flight at a time.
// Ports: in_valid/in_ready/in_rs/in_data command port; i2c_ena/i2c_data_wr/i2c_busy/
//        i2c_ack_error to i2c_master; idle status; err_sticky latched error, cleared by err_clr.
module lcd_byte_scheduler
   import lcd_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int CMD_DELAY_US = 50,
   parameter int CLR_DELAY_US = 2000,
   parameter int BACKLIGHT    = 1,
   parameter int BUSY_TO_CYC  = 1_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       i2c_ena,
   output logic [7:0] i2c_data_wr,
   input  logic       i2c_busy,
   input  logic       i2c_ack_error,
   output logic       idle,
   output logic       err_sticky,
   input  logic       err_clr
);

   localparam int CYC_PER_US = CLK_HZ / 1_000_000;
   localparam int CMD_CYC    = CYC_PER_US * CMD_DELAY_US;
   localparam int CLR_CYC    = CYC_PER_US * CLR_DELAY_US;
   localparam int MAX_CYC    = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
   localparam int DW         = $clog2(MAX_CYC + 1);
   // Timer is loaded with N-1 on the exit edge so DELAY lasts exactly N cycles.
   localparam logic [DW-1:0] CMD_LOAD = DW'(CMD_CYC - 1);
   localparam logic [DW-1:0] CLR_LOAD = DW'(CLR_CYC - 1);
   localparam int TW         = $clog2(BUSY_TO_CYC + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO_CYC - 1);
   localparam logic BL       = (BACKLIGHT != 0);

   state_t        state;
   logic          rs_q;
   logic [7:0]    data_q;
   logic [1:0]    nib_idx;
   logic [TW-1:0] busy_to_cnt;

   logic          busy_timeout;
   logic          last_fall;
   logic          err_set;
   logic          dly_load;
   logic [DW-1:0] dly_val;
   logic          dly_done;

   assign busy_timeout = (state == ST_WAIT_HI) && !i2c_busy && (busy_to_cnt == TO_LAST);
   assign last_fall    = (state == ST_WAIT_LO) && !i2c_busy && (nib_idx == 2'd3);
   // Ack errors count only while the transaction is actually running.
   assign err_set      = busy_timeout || ((state == ST_WAIT_LO) && i2c_busy && i2c_ack_error);
   assign dly_load     = busy_timeout || last_fall;
   assign dly_val      = is_long_cmd(rs_q, data_q) ? CLR_LOAD : CMD_LOAD;

   assign in_ready = (state == ST_IDLE);
   assign idle     = (state == ST_IDLE);

   lcd_delay_timer #(.W(DW)) u_delay (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (dly_load),
      .load_val (dly_val),
      .done     (dly_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         nib_idx     <= 2'd0;
         busy_to_cnt <= '0;
         i2c_ena     <= 1'b0;
         i2c_data_wr <= {4'b0000, BL, 3'b000};
         err_sticky  <= 1'b0;
      end else begin
         // A new error takes priority over a simultaneous clear.
         if (err_set) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  rs_q        <= in_rs;
                  data_q      <= in_data;
                  nib_idx     <= 2'd0;
                  // Frame is set up a cycle before ena so the master sees stable data.
                  i2c_data_wr <= make_frame(in_rs, in_data, 2'd0, BL);
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               i2c_ena     <= 1'b1;
               busy_to_cnt <= '0;
               state       <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (i2c_busy) begin
                  i2c_ena <= 1'b0;
                  state   <= ST_WAIT_LO;
               end else if (busy_to_cnt == TO_LAST) begin
                  // Master never started: drop the rest of the byte, still honour the hold-off.
                  i2c_ena <= 1'b0;
                  state   <= ST_DELAY;
               end else begin
                  busy_to_cnt <= busy_to_cnt + TW'(1);
               end
            end
            ST_WAIT_LO: begin
               if (!i2c_busy) begin
                  if (nib_idx == 2'd3) begin
                     state <= ST_DELAY;
                  end else begin
                     nib_idx     <= nib_idx + 2'd1;
                     i2c_data_wr <= make_frame(rs_q, data_q, nib_idx + 2'd1, BL);
                     state       <= ST_ISSUE;
                  end
               end
            end
            ST_DELAY: begin
               if (dly_done) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_byte_scheduler.sv
// Bench for lcd_byte_scheduler with a behavioural i2c_master and a frame scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_byte_scheduler;
   import lcd_pkg::*;

   localparam int TO_CYC = 200;
   localparam int CMD_N  = 50;
   localparam int CLR_N  = 2000;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       i2c_ena;
   logic [7:0] i2c_data_wr;
   logic       i2c_busy;
   logic       i2c_ack_error;
   logic       idle;
   logic       err_sticky;
   logic       err_clr;

   always #5 clk = ~clk;

   lcd_byte_scheduler #(
      .CLK_HZ       (1_000_000),
      .CMD_DELAY_US (CMD_N),
      .CLR_DELAY_US (CLR_N),
      .BACKLIGHT    (1),
      .BUSY_TO_CYC  (TO_CYC)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs         (in_rs),
      .in_data       (in_data),
      .i2c_ena       (i2c_ena),
      .i2c_data_wr   (i2c_data_wr),
      .i2c_busy      (i2c_busy),
      .i2c_ack_error (i2c_ack_error),
      .idle          (idle),
      .err_sticky    (err_sticky),
      .err_clr       (err_clr)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // i2c_master model state
   logic       m_busy    = 1'b0;
   logic       m_ack     = 1'b0;
   logic       force_ack = 1'b0;
   bit         never_busy = 1'b0;
   int         ack_err_txn = -1;
   int         long_txn    = -1;
   int         txn_cnt     = 0;
   int         last_fall   = 0;
   logic [7:0] sb[$];

   assign i2c_busy      = m_busy;
   assign i2c_ack_error = m_ack | force_ack;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Model: picks up each ena, checks the frame against the scoreboard, then runs a
   // busy window starting 3-20 cycles later and lasting 1-8 cycles.
   initial begin : i2c_model
      logic [7:0] got;
      logic [7:0] exp;
      bit         stable;
      int         len;
      forever begin
         @(posedge clk); #1;
         if (i2c_ena && !never_busy) begin
            got = i2c_data_wr;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame_unexpected got %02h required no frame", got);
            end else begin
               exp = sb.pop_front();
               chk("frame", int'(got), int'(exp));
            end
            stable = 1'b1;
            repeat ($urandom_range(3, 20)) begin
               @(posedge clk); #1;
               if (reset_n && i2c_data_wr !== got) stable = 1'b0;
            end
            m_busy = 1'b1;
            if (txn_cnt == ack_err_txn) m_ack = 1'b1;
            len = (txn_cnt == long_txn) ? 8 : $urandom_range(1, 8);
            repeat (len) begin
               @(posedge clk); #1;
               if (reset_n && i2c_data_wr !== got) stable = 1'b0;
            end
            m_busy    = 1'b0;
            m_ack     = 1'b0;
            last_fall = cyc;
            txn_cnt++;
            chk("data_stable", int'(stable), 1);
         end
      end
   end

   function automatic logic [31:0] exp_frames(input logic rs, input logic [7:0] d);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = {d[7:4], 4'b1000} | {7'b0, rs};
      lo = {d[3:0], 4'b1000} | {7'b0, rs};
      return {hi | 8'h04, hi, lo | 8'h04, lo};
   endfunction

   // Offers a byte until accepted; the expected frames go on the scoreboard at accept.
   task automatic send_byte(input logic rs, input logic [7:0] d, input logic [31:0] fr,
                            input bit push, input bit keep);
      bit ok;
      in_valid = 1'b1;
      in_rs    = rs;
      in_data  = d;
      ok       = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got in_ready=0 required 1");
      end
      @(posedge clk); #1;
      if (push) begin
         sb.push_back(fr[31:24]);
         sb.push_back(fr[23:16]);
         sb.push_back(fr[15:8]);
         sb.push_back(fr[7:0]);
      end
      if (!keep) in_valid = 1'b0;
      chk("ready_low_after_accept", int'(in_ready), 0);
   endtask

   task automatic wait_ready(output int when);
      when = -1;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         if (in_ready) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got in_ready=0 required 1");
      end
   endtask

   typedef struct {
      logic        rs;
      logic [7:0]  d;
      logic [31:0] fr;
      int          dly;
   } vec_t;

   vec_t vt[11];

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t;
      int base;
      int hi;
      int drop_cyc;
      int acc;
      bit seen;

      vt[0]  = '{1'b1, 8'h48,           32'h4D498D89, CMD_N};
      vt[1]  = '{1'b0, OP_CLEAR,        32'h0C081C18, CLR_N};
      vt[2]  = '{1'b0, OP_FUNC_4BIT_2L, 32'h2C288C88, CMD_N};
      vt[3]  = '{1'b0, OP_HOME,         32'h0C082C28, CLR_N};
      vt[4]  = '{1'b0, 8'h03,           32'h0C083C38, CLR_N};
      vt[5]  = '{1'b1, 8'h01,           32'h0D091D19, CMD_N};
      vt[6]  = '{1'b0, 8'h04,           32'h0C084C48, CMD_N};
      vt[7]  = '{1'b0, 8'h00,           32'h0C080C08, CMD_N};
      vt[8]  = '{1'b0, OP_DISP_ON,      32'h0C08CCC8, CMD_N};
      vt[9]  = '{1'b0, OP_ENTRY_INC,    32'h0C086C68, CMD_N};
      vt[10] = '{1'b0, OP_DDRAM_L2,     32'hCCC80C08, CMD_N};

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_rs    = 1'b0;
      in_data  = 8'h00;
      err_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ena", int'(i2c_ena), 0);
      chk("rst_data", int'(i2c_data_wr), 8'h08);
      chk("rst_idle", int'(idle), 1);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_err", int'(err_sticky), 0);
      reset_n = 1'b1;

      // Per byte: 4 frames in order, 4 transactions, hold-off. The fall is sampled at the
      // next edge, then N hold-off cycles run, so in_ready rises N+1 edges after the fall.
      for (int i = 0; i < 11; i++) begin
         base = txn_cnt;
         send_byte(vt[i].rs, vt[i].d, vt[i].fr, 1'b1, 1'b0);
         wait_ready(t);
         chk("sb_empty", sb.size(), 0);
         chk("ena_pulses", txn_cnt - base, 4);
         chk("holdoff", t - last_fall, vt[i].dly + 1);
         chk("no_err", int'(err_sticky), 0);
      end

      // Ack error on the second transaction: byte still completes, error latches.
      base        = txn_cnt;
      ack_err_txn = txn_cnt + 1;
      send_byte(1'b1, 8'h65, exp_frames(1'b1, 8'h65), 1'b1, 1'b0);
      wait_ready(t);
      ack_err_txn = -1;
      chk("ackerr_sticky", int'(err_sticky), 1);
      chk("ackerr_all_frames", txn_cnt - base, 4);
      chk("ackerr_sb_empty", sb.size(), 0);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("errclr", int'(err_sticky), 0);

      // Ack error while idle is ignored.
      force_ack = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      force_ack = 1'b0;
      chk("ack_idle_ignored", int'(err_sticky), 0);

      // Busy never rises: ena held TO_CYC cycles, then dropped; err wins over a held err_clr.
      never_busy = 1'b1;
      base       = txn_cnt;
      err_clr    = 1'b1;
      send_byte(1'b1, 8'h41, 32'h0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (i2c_ena) begin
            seen = 1'b1;
            break;
         end
      end
      chk("to_ena_seen", int'(seen), 1);
      hi = 0;
      while (i2c_ena && hi < 1000) begin
         hi++;
         @(posedge clk); #1;
      end
      drop_cyc = cyc;
      chk("to_ena_cycles", hi, TO_CYC);
      chk("to_err_wins", int'(err_sticky), 1);
      @(posedge clk); #1;
      chk("to_errclr", int'(err_sticky), 0);
      err_clr = 1'b0;
      wait_ready(t);
      chk("to_holdoff", t - drop_cyc, CMD_N);
      chk("to_no_txn", txn_cnt - base, 0);
      never_busy = 1'b0;

      // Three bytes with in_valid held high throughout.
      base = txn_cnt;
      acc  = 0;
      send_byte(1'b1, 8'h61, exp_frames(1'b1, 8'h61), 1'b1, 1'b1);
      acc++;
      send_byte(1'b1, 8'h62, exp_frames(1'b1, 8'h62), 1'b1, 1'b1);
      acc++;
      send_byte(1'b1, 8'h63, exp_frames(1'b1, 8'h63), 1'b1, 1'b0);
      acc++;
      wait_ready(t);
      chk("b2b_accepts", acc, 3);
      chk("b2b_frames", txn_cnt - base, 12);
      chk("b2b_sb_empty", sb.size(), 0);

      // Reset while WAIT_LO of nibble 2.
      base     = txn_cnt;
      long_txn = base + 2;
      send_byte(1'b1, 8'h48, 32'h4D498D89, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (txn_cnt == base + 2 && m_busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rst_mid_reached", int'(seen), 1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_ena", int'(i2c_ena), 0);
      chk("rstmid_data", int'(i2c_data_wr), 8'h08);
      chk("rstmid_idle", int'(idle), 1);
      chk("rstmid_ready", int'(in_ready), 1);
      for (int i = 0; i < 50 && m_busy; i++) begin
         @(posedge clk); #1;
      end
      long_txn = -1;
      reset_n  = 1'b1;
      sb.delete();

      // Recovery after the mid-byte reset.
      base = txn_cnt;
      send_byte(vt[0].rs, vt[0].d, vt[0].fr, 1'b1, 1'b0);
      wait_ready(t);
      chk("recover_pulses", txn_cnt - base, 4);
      chk("recover_holdoff", t - last_fall, CMD_N + 1);
      chk("recover_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
